control_unit: RTL and testbench

- Finite-state sequencer for the K-and-S processor.
- Consumes `decoded_instruction` and the four registered ALU flags from the datapath.
- Drives every datapath control strobe (`branch`, `pc_enable`, `ir_enable`, `addr_sel`, `c_sel`, `operation`, `write_reg_enable`, `flags_reg_enable`) plus the RAM write strobe.
- Counts retired instructions and reports `halt`. Sits beside `data_path` inside the processor top.

---
 rtl/control_unit.sv | 266 ++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// K-and-S processor sequencer.
// Package k_and_s_pkg: instruction decode enumeration shared with the datapath.
// Module control_unit: multi-cycle FSM driving the datapath control strobes and the RAM write strobe.
//   Inputs : clk, rst_n (async, active-low), decoded_instruction, zero_op, neg_op,
//            unsigned_overflow, signed_overflow (reserved, unused).
//   Outputs: branch, pc_enable, ir_enable, addr_sel, c_sel, operation[1:0],
//            write_reg_enable, flags_reg_enable, ram_write_enable, halt,
//            instr_count[CNT_W-1:0] (saturating count of retired instructions).

package k_and_s_pkg;

    localparam int unsigned INSTR_W = 4;
    localparam int unsigned ALU_OP_W = 2;

    typedef enum logic [INSTR_W-1:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_BOV    = 4'd13,
        I_BNOV   = 4'd14,
        I_HALT   = 4'd15
    } decoded_instruction_type;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 2'b11;

endpackage

module control_unit
    import k_and_s_pkg::*;
#(
    parameter int unsigned RAM_RD_LAT = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [ALU_OP_W-1:0]     operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt,
    output logic [CNT_W-1:0]        instr_count
);

    localparam int unsigned WAIT_W = 2;
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(RAM_RD_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_ALU    = 3'd2,
        S_MOVE   = 3'd3,
        S_LOAD   = 3'd4,
        S_STORE  = 3'd5,
        S_BRANCH = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                retire_c;
    logic                taken_c;
    logic                last_wait_c;

    // signed_overflow is reserved: no branch condition consumes it.
    logic unused_sovf;
    assign unused_sovf = signed_overflow;

    assign last_wait_c = (wait_q == LAST_WAIT);

    // Branch condition from the flags currently held in the flag register.
    always_comb begin
        taken_c = 1'b0;
        case (decoded_instruction)
            I_BRANCH: taken_c = 1'b1;
            I_BZERO:  taken_c = zero_op;
            I_BNZERO: taken_c = ~zero_op;
            I_BNEG:   taken_c = neg_op;
            I_BNNEG:  taken_c = ~neg_op;
            I_BOV:    taken_c = unsigned_overflow;
            I_BNOV:   taken_c = ~unsigned_overflow;
            default:  taken_c = 1'b0;
        endcase
    end

    // Next-state, wait counter and retire detection.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        retire_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (last_wait_c) begin
                    state_d = S_DECODE;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                case (decoded_instruction)
                    I_ADD, I_SUB, I_AND, I_OR: state_d = S_ALU;
                    I_MOVE:                    state_d = S_MOVE;
                    I_LOAD:                    state_d = S_LOAD;
                    I_STORE:                   state_d = S_STORE;
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
                    I_BNNEG, I_BOV, I_BNOV:    state_d = S_BRANCH;
                    I_HALT:                    state_d = S_HALT;
                    default: begin
                        // NOP completes here.
                        state_d  = S_FETCH;
                        retire_c = 1'b1;
                    end
                endcase
            end
            S_ALU, S_MOVE, S_STORE, S_BRANCH: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            S_LOAD: begin
                if (last_wait_c) begin
                    state_d  = S_FETCH;
                    wait_d   = '0;
                    retire_c = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_HALT: state_d = S_HALT;
            default: begin
                state_d = S_FETCH;
                wait_d  = '0;
            end
        endcase
    end

    // State, wait counter and saturating retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire_c && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign instr_count = cnt_q;

    logic                branch_c;
    logic                pc_enable_c;
    logic                ir_enable_c;
    logic                addr_sel_c;
    logic                c_sel_c;
    logic [ALU_OP_W-1:0] operation_c;
    logic                write_reg_enable_c;
    logic                flags_reg_enable_c;
    logic                ram_write_enable_c;
    logic                halt_c;

    // Moore decode of the strobes from the state registers (branch also uses flags).
    always_comb begin
        branch_c           = 1'b0;
        pc_enable_c        = 1'b0;
        ir_enable_c        = 1'b0;
        addr_sel_c         = 1'b0;
        c_sel_c            = 1'b0;
        operation_c        = ALU_ADD;
        write_reg_enable_c = 1'b0;
        flags_reg_enable_c = 1'b0;
        ram_write_enable_c = 1'b0;
        halt_c             = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_enable_c = last_wait_c;
            end
            S_DECODE: begin
                pc_enable_c = 1'b1;
            end
            S_ALU: begin
                case (decoded_instruction)
                    I_SUB:   operation_c = ALU_SUB;
                    I_AND:   operation_c = ALU_AND;
                    I_OR:    operation_c = ALU_OR;
                    default: operation_c = ALU_ADD;
                endcase
                c_sel_c            = 1'b1;
                write_reg_enable_c = 1'b1;
                flags_reg_enable_c = 1'b1;
            end
            S_MOVE: begin
                // Move is A|A through the ALU without touching the flags.
                operation_c        = ALU_OR;
                c_sel_c            = 1'b1;
                write_reg_enable_c = 1'b1;
            end
            S_LOAD: begin
                addr_sel_c         = 1'b1;
                write_reg_enable_c = last_wait_c;
            end
            S_STORE: begin
                addr_sel_c         = 1'b1;
                ram_write_enable_c = 1'b1;
            end
            S_BRANCH: begin
                // Not taken: PC already advanced in decode, so nothing to do.
                branch_c    = taken_c;
                pc_enable_c = taken_c;
                addr_sel_c  = taken_c;
            end
            S_HALT: begin
                halt_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset forces every strobe low, even though the reset state decodes as a fetch.
    assign branch           = branch_c & rst_n;
    assign pc_enable        = pc_enable_c & rst_n;
    assign ir_enable        = ir_enable_c & rst_n;
    assign addr_sel         = addr_sel_c & rst_n;
    assign c_sel            = c_sel_c & rst_n;
    assign operation        = operation_c & {ALU_OP_W{rst_n}};
    assign write_reg_enable = write_reg_enable_c & rst_n;
    assign flags_reg_enable = flags_reg_enable_c & rst_n;
    assign ram_write_enable = ram_write_enable_c & rst_n;
    assign halt             = halt_c & rst_n;

    // IR capture, register write and RAM write are mutually exclusive.
    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({ir_enable, write_reg_enable, ram_write_enable}));

    // Flags are only captured alongside a register write.
    a_flags_with_wr: assert property (@(posedge clk) disable iff (!rst_n)
        flags_reg_enable |-> write_reg_enable);

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit.
// Three instances: u_lat1 (RAM_RD_LAT=1), u_lat3 (RAM_RD_LAT=3), u_cnt4 (CNT_W=4).
// Strobe vector packing, MSB first: branch, pc_enable, ir_enable, addr_sel, c_sel,
// operation[1:0], write_reg_enable, flags_reg_enable, ram_write_enable, halt.

module tb_control_unit;
    import k_and_s_pkg::*;

    logic clk;
    logic rstn [3];
    decoded_instruction_type instr;
    logic zero_op, neg_op, uovf, sovf;

    logic       br   [3];
    logic       pce  [3];
    logic       ire  [3];
    logic       asel [3];
    logic       csel [3];
    logic [1:0] op   [3];
    logic       wre  [3];
    logic       fre  [3];
    logic       rwe  [3];
    logic       hlt  [3];
    logic [15:0] cnt_lat1, cnt_lat3;
    logic [3:0]  cnt_c4;

    int checks = 0;
    int errors = 0;

    localparam logic [10:0] V_IDLE   = 11'h000;
    localparam logic [10:0] V_FETCH  = 11'h100;
    localparam logic [10:0] V_DEC    = 11'h200;
    localparam logic [10:0] V_ADD    = 11'h04C;
    localparam logic [10:0] V_SUB    = 11'h05C;
    localparam logic [10:0] V_AND    = 11'h06C;
    localparam logic [10:0] V_OR     = 11'h07C;
    localparam logic [10:0] V_MOVE   = 11'h078;
    localparam logic [10:0] V_TAKEN  = 11'h680;
    localparam logic [10:0] V_LDWAIT = 11'h080;
    localparam logic [10:0] V_LDWR   = 11'h088;
    localparam logic [10:0] V_STORE  = 11'h082;
    localparam logic [10:0] V_HALT   = 11'h001;

    control_unit #(.RAM_RD_LAT(1), .CNT_W(16)) u_lat1 (
        .clk(clk), .rst_n(rstn[0]), .decoded_instruction(instr),
        .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uovf), .signed_overflow(sovf),
        .branch(br[0]), .pc_enable(pce[0]), .ir_enable(ire[0]), .addr_sel(asel[0]),
        .c_sel(csel[0]), .operation(op[0]), .write_reg_enable(wre[0]),
        .flags_reg_enable(fre[0]), .ram_write_enable(rwe[0]), .halt(hlt[0]),
        .instr_count(cnt_lat1));

    control_unit #(.RAM_RD_LAT(3), .CNT_W(16)) u_lat3 (
        .clk(clk), .rst_n(rstn[1]), .decoded_instruction(instr),
        .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uovf), .signed_overflow(sovf),
        .branch(br[1]), .pc_enable(pce[1]), .ir_enable(ire[1]), .addr_sel(asel[1]),
        .c_sel(csel[1]), .operation(op[1]), .write_reg_enable(wre[1]),
        .flags_reg_enable(fre[1]), .ram_write_enable(rwe[1]), .halt(hlt[1]),
        .instr_count(cnt_lat3));

    control_unit #(.RAM_RD_LAT(1), .CNT_W(4)) u_cnt4 (
        .clk(clk), .rst_n(rstn[2]), .decoded_instruction(instr),
        .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uovf), .signed_overflow(sovf),
        .branch(br[2]), .pc_enable(pce[2]), .ir_enable(ire[2]), .addr_sel(asel[2]),
        .c_sel(csel[2]), .operation(op[2]), .write_reg_enable(wre[2]),
        .flags_reg_enable(fre[2]), .ram_write_enable(rwe[2]), .halt(hlt[2]),
        .instr_count(cnt_c4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [10:0] strobes(input int k);
        return {br[k], pce[k], ire[k], asel[k], csel[k], op[k], wre[k], fre[k], rwe[k], hlt[k]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_rst(input int k);
        @(negedge clk);
        rstn[k] = 1'b1;
        #1;
    endtask

    // Starts sampled in a FETCH cycle of u_lat1; ends sampled in the next FETCH cycle.
    task automatic exec1(input string tag, input decoded_instruction_type ins,
                         input logic z, input logic n, input logic v, input logic [10:0] exp);
        instr   = ins;
        zero_op = z;
        neg_op  = n;
        uovf    = v;
        check({tag, "_fetch"}, 32'(strobes(0)), 32'(V_FETCH));
        step();
        check({tag, "_decode"}, 32'(strobes(0)), 32'(V_DEC));
        step();
        check({tag, "_exec"}, 32'(strobes(0)), 32'(exp));
        step();
    endtask

    initial begin
        rstn[0] = 1'b0;
        rstn[1] = 1'b0;
        rstn[2] = 1'b0;
        instr   = I_NOP;
        zero_op = 1'b0;
        neg_op  = 1'b0;
        uovf    = 1'b0;
        sovf    = 1'b0;

        // Reset state: every strobe low even though the FETCH state would raise ir_enable.
        #12;
        check("rst_strobes", 32'(strobes(0)), 32'(V_IDLE));
        check("rst_count", 32'(cnt_lat1), 32'd0);

        // NOP stream: ir_enable and pc_enable alternate, 5 retired after 10 cycles.
        release_rst(0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("nop_c%0d", i), 32'(strobes(0)), 32'((i % 2 == 0) ? V_FETCH : V_DEC));
            step();
        end
        check("nop_count", 32'(cnt_lat1), 32'd5);

        // ALU-class and MOVE.
        exec1("add",  I_ADD,  1'b0, 1'b0, 1'b0, V_ADD);
        exec1("sub",  I_SUB,  1'b0, 1'b0, 1'b0, V_SUB);
        exec1("and",  I_AND,  1'b0, 1'b0, 1'b0, V_AND);
        exec1("or",   I_OR,   1'b0, 1'b0, 1'b0, V_OR);
        exec1("move", I_MOVE, 1'b0, 1'b0, 1'b0, V_MOVE);
        check("alu_count", 32'(cnt_lat1), 32'd10);

        // Branch conditions, taken and not taken.
        exec1("br",        I_BRANCH, 1'b0, 1'b0, 1'b0, V_TAKEN);
        exec1("bz_t",      I_BZERO,  1'b1, 1'b0, 1'b0, V_TAKEN);
        exec1("bz_nt",     I_BZERO,  1'b0, 1'b0, 1'b0, V_IDLE);
        exec1("bnz_t",     I_BNZERO, 1'b0, 1'b0, 1'b0, V_TAKEN);
        exec1("bneg_t",    I_BNEG,   1'b0, 1'b1, 1'b0, V_TAKEN);
        exec1("bnneg_nt",  I_BNNEG,  1'b0, 1'b1, 1'b0, V_IDLE);
        exec1("bov_t",     I_BOV,    1'b0, 1'b0, 1'b1, V_TAKEN);
        exec1("bnov_nt",   I_BNOV,   1'b0, 1'b0, 1'b1, V_IDLE);
        check("br_count", 32'(cnt_lat1), 32'd18);

        // LOAD and STORE at latency 1, then HALT.
        exec1("load1", I_LOAD,  1'b0, 1'b0, 1'b0, V_LDWR);
        exec1("store", I_STORE, 1'b0, 1'b0, 1'b0, V_STORE);
        check("store_next_fetch", 32'(strobes(0)), 32'(V_FETCH));
        instr = I_HALT;
        step();
        check("halt_decode", 32'(strobes(0)), 32'(V_DEC));
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("halt_hold%0d", i), 32'(strobes(0)), 32'(V_HALT));
        end
        check("halt_count", 32'(cnt_lat1), 32'd20);

        // LOAD with a 3-cycle read latency.
        instr = I_LOAD;
        release_rst(1);
        begin
            logic [10:0] seq [8];
            seq = '{V_IDLE, V_IDLE, V_FETCH, V_DEC, V_LDWAIT, V_LDWAIT, V_LDWR, V_IDLE};
            for (int i = 0; i < 8; i++) begin
                check($sformatf("ld3_c%0d", i), 32'(strobes(1)), 32'(seq[i]));
                if (i < 7) step();
            end
        end
        check("ld3_count", 32'(cnt_lat3), 32'd1);

        // Reset in the middle of a LOAD wait: strobes drop at once, count clears.
        step();
        step();
        check("ld3b_fetch", 32'(strobes(1)), 32'(V_FETCH));
        step();
        step();
        check("ld3b_wait", 32'(strobes(1)), 32'(V_LDWAIT));
        #2;
        rstn[1] = 1'b0;
        #1;
        check("midrst_strobes", 32'(strobes(1)), 32'(V_IDLE));
        check("midrst_count", 32'(cnt_lat3), 32'd0);
        release_rst(1);
        check("restart_c0", 32'(strobes(1)), 32'(V_IDLE));
        step();
        step();
        check("restart_c2", 32'(strobes(1)), 32'(V_FETCH));
        check("restart_count", 32'(cnt_lat3), 32'd0);

        // 4-bit counter saturates at 15.
        instr = I_NOP;
        release_rst(2);
        for (int i = 0; i < 28; i++) step();
        check("sat_14", 32'(cnt_c4), 32'd14);
        step();
        step();
        check("sat_15", 32'(cnt_c4), 32'd15);
        for (int i = 0; i < 10; i++) step();
        check("sat_hold", 32'(cnt_c4), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
